// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//
// Register file fed by the write-back stage.
//   - 32 x 32-bit general purpose registers; register 0 reads as zero and
//     ignores writes.
//   - HI/LO pair written together.
//   - Free-running counter of committed GPR writes, wrapping at 2^32.
//   - Two independent combinational read ports with a same-cycle bypass of
//     the write-back data, so a consumer reading the register being written
//     this cycle sees the new value.
//
// Ports
//   clk       in   1   clock, all state updates on rising edge
//   rst       in   1   asynchronous reset, active low (0 = in reset)
//   wb_wd     in   5   GPR write address
//   wb_wreg   in   1   GPR write enable
//   wb_wdata  in  32   GPR write data
//   wb_hi     in  32   HI write data
//   wb_lo     in  32   LO write data
//   wb_whilo  in   1   HI/LO write enable
//   re1       in   1   read port 1 enable
//   raddr1    in   5   read port 1 address
//   rdata1    out 32   read port 1 data
//   re2       in   1   read port 2 enable
//   raddr2    in   5   read port 2 address
//   rdata2    out 32   read port 2 data
//   hi_o      out 32   HI value, bypassed from wb_hi while being written
//   lo_o      out 32   LO value, bypassed from wb_lo while being written
//   wb_cnt    out 32   number of committed GPR writes
// ---------------------------------------------------------------------------
module wb_regfile #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              wb_whilo,
    input  logic              re1,
    input  logic [4:0]        raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [4:0]        raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [DATA_W-1:0] wb_cnt
);

    logic [DATA_W-1:0] gpr_q [32];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] cnt_q;

    // A GPR write only commits for a non-zero destination.
    logic gpr_wr;
    assign gpr_wr = wb_wreg && (wb_wd != 5'd0);

    // Read port selection: reset, disabled port and register 0 all yield
    // zero; otherwise the in-flight write-back data wins over the array.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic              rst_n_v,
        input logic              en,
        input logic [4:0]        addr,
        input logic              byp_hit,
        input logic [DATA_W-1:0] byp_data,
        input logic [DATA_W-1:0] arr_data
    );
        if (!rst_n_v || !en || (addr == 5'd0)) begin
            return '0;
        end
        if (byp_hit) begin
            return byp_data;
        end
        return arr_data;
    endfunction

    // ---- state update (rising edge, async clear) ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= '0;
            end
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (gpr_wr) begin
                gpr_q[wb_wd] <= wb_wdata;
                cnt_q        <= cnt_q + 1'b1;
            end
            if (wb_whilo) begin
                hi_q <= wb_hi;
                lo_q <= wb_lo;
            end
        end
    end

    // ---- combinational read side ----
    logic byp1;
    logic byp2;

    assign byp1 = wb_wreg && (raddr1 == wb_wd);
    assign byp2 = wb_wreg && (raddr2 == wb_wd);

    assign rdata1 = read_sel(rst, re1, raddr1, byp1, wb_wdata, gpr_q[raddr1]);
    assign rdata2 = read_sel(rst, re2, raddr2, byp2, wb_wdata, gpr_q[raddr2]);

    assign hi_o   = !rst ? '0 : (wb_whilo ? wb_hi : hi_q);
    assign lo_o   = !rst ? '0 : (wb_whilo ? wb_lo : lo_q);

    // Counter is already cleared by the async reset, so no output gating.
    assign wb_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//
// Self-checking bench for wb_regfile. Directed scenarios for reset, write,
// register-0 guard, bypass, HI/LO, async reset and counter wrap, followed by
// randomized traffic compared against a behavioural model of the register
// file held in plain arrays.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] wb_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_gpr [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_cnt;

    wb_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .wb_wd    (wb_wd),
        .wb_wreg  (wb_wreg),
        .wb_wdata (wb_wdata),
        .wb_hi    (wb_hi),
        .wb_lo    (wb_lo),
        .wb_whilo (wb_whilo),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .wb_cnt   (wb_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_gpr[i] = '0;
        m_hi  = '0;
        m_lo  = '0;
        m_cnt = '0;
    endtask

    // Expected read value from the current inputs and model contents.
    function automatic logic [31:0] exp_read(input logic en, input logic [4:0] addr);
        if (!rst || !en || addr == 0) return '0;
        if (wb_wreg && wb_wd == addr) return wb_wdata;
        return m_gpr[addr];
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_rd1"}, rdata1, exp_read(re1, raddr1));
        check({tag, "_rd2"}, rdata2, exp_read(re2, raddr2));
        check({tag, "_hi"},  hi_o,   !rst ? 32'h0 : (wb_whilo ? wb_hi : m_hi));
        check({tag, "_lo"},  lo_o,   !rst ? 32'h0 : (wb_whilo ? wb_lo : m_lo));
        check({tag, "_cnt"}, wb_cnt, m_cnt);
    endtask

    task automatic idle_inputs();
        wb_wd = 0; wb_wreg = 0; wb_wdata = 0;
        wb_hi = 0; wb_lo = 0; wb_whilo = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    endtask

    // Called right after a negedge with inputs already driven: clock one
    // rising edge, update the model, return at the following negedge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            if (wb_wreg && wb_wd != 0) begin
                m_gpr[wb_wd] = wb_wdata;
                m_cnt        = m_cnt + 1;
            end
            if (wb_whilo) begin
                m_hi = wb_hi;
                m_lo = wb_lo;
            end
        end
        @(negedge clk);
    endtask

    task automatic write_gpr(input logic [4:0] a, input logic [31:0] d);
        idle_inputs();
        wb_wreg = 1; wb_wd = a; wb_wdata = d;
        step();
        idle_inputs();
    endtask

    initial begin
        model_clear();
        idle_inputs();
        rst = 1'b0;

        // Reset state: outputs zero even with enables and a write presented.
        @(negedge clk);
        re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 9;
        wb_wreg = 1; wb_wd = 5; wb_wdata = 32'hDEAD_BEEF;
        wb_whilo = 1; wb_hi = 32'h11; wb_lo = 32'h22;
        #1;
        check_outputs("rst_hold");
        check("rst_rd1_zero", rdata1, 32'h0);
        step();
        check_outputs("rst_after_edge");

        // Release, write GPR5 and read it back next cycle.
        idle_inputs();
        rst = 1'b1;
        #1;
        check_outputs("rel_idle");
        write_gpr(5, 32'h1234_5678);
        re1 = 1; raddr1 = 5;
        #1;
        check("gpr5_read", rdata1, 32'h1234_5678);
        check("gpr5_cnt", wb_cnt, 32'd1);
        check_outputs("gpr5");

        // Register 0 guard.
        idle_inputs();
        wb_wreg = 1; wb_wd = 0; wb_wdata = 32'hFFFF_FFFF;
        re1 = 1; raddr1 = 0;
        #1;
        check("r0_during", rdata1, 32'h0);
        step();
        wb_wreg = 0;
        #1;
        check("r0_after", rdata1, 32'h0);
        check("r0_cnt", wb_cnt, 32'd1);

        // Bypass on both ports, then port 2 disabled.
        write_gpr(7, 32'hA);
        wb_wreg = 1; wb_wd = 7; wb_wdata = 32'hB;
        re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 7;
        #1;
        check("byp_rd1", rdata1, 32'hB);
        check("byp_rd2", rdata2, 32'hB);
        re2 = 0;
        #1;
        check("byp_rd2_dis", rdata2, 32'h0);
        check_outputs("byp");
        step();

        // HI/LO write, bypass and hold.
        idle_inputs();
        wb_whilo = 1; wb_hi = 32'h1; wb_lo = 32'h2;
        #1;
        check("hilo_comb_hi", hi_o, 32'h1);
        check("hilo_comb_lo", lo_o, 32'h2);
        step();
        wb_whilo = 0; wb_hi = 32'h55; wb_lo = 32'h66;
        #1;
        check("hilo_hold_hi", hi_o, 32'h1);
        check("hilo_hold_lo", lo_o, 32'h2);
        step();
        check("hilo_hold2_hi", hi_o, 32'h1);

        // Simultaneous GPR and HI/LO write.
        idle_inputs();
        wb_wreg = 1; wb_wd = 12; wb_wdata = 32'hCAFE_0012;
        wb_whilo = 1; wb_hi = 32'hAAAA_0000; wb_lo = 32'h0000_BBBB;
        step();
        idle_inputs();
        re2 = 1; raddr2 = 12;
        #1;
        check("both_gpr", rdata2, 32'hCAFE_0012);
        check("both_hi", hi_o, 32'hAAAA_0000);
        check_outputs("both");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            wb_wreg  = ($urandom_range(0, 3) != 0);
            wb_wd    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wb_wdata = $urandom;
            wb_whilo = ($urandom_range(0, 3) == 0);
            wb_hi    = $urandom;
            wb_lo    = $urandom;
            re1      = ($urandom_range(0, 7) != 0);
            re2      = ($urandom_range(0, 7) != 0);
            raddr1   = ($urandom_range(0, 2) == 0) ? wb_wd : 5'($urandom_range(0, 7));
            raddr2   = ($urandom_range(0, 2) == 0) ? raddr1 : 5'($urandom);
            #1;
            check_outputs("rand");
            if (re1 && re2 && raddr1 == raddr2) check("rand_same", rdata2, rdata1);
            step();
        end

        // Async reset pulse between edges.
        write_gpr(5, 32'h5555_AAAA);
        re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 12;
        wb_whilo = 1; wb_hi = 32'h9; wb_lo = 32'h8;
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        check("arst_rd1", rdata1, 32'h0);
        check("arst_rd2", rdata2, 32'h0);
        check("arst_hi", hi_o, 32'h0);
        check("arst_lo", lo_o, 32'h0);
        check("arst_cnt", wb_cnt, 32'h0);
        rst = 1'b1;
        wb_whilo = 0;
        #1;
        check("arst_gpr5", rdata1, 32'h0);
        check_outputs("arst_rel");
        @(negedge clk);

        // Write presented while in reset is lost; next enabled edge commits.
        idle_inputs();
        rst = 1'b0;
        wb_wreg = 1; wb_wd = 3; wb_wdata = 32'h3333_3333;
        step();
        rst = 1'b1;
        wb_wreg = 0;
        re1 = 1; raddr1 = 3;
        #1;
        check("lost_gpr3", rdata1, 32'h0);
        check("lost_cnt", wb_cnt, 32'h0);
        write_gpr(3, 32'h4444_4444);
        re1 = 1; raddr1 = 3;
        #1;
        check("post_rst_gpr3", rdata1, 32'h4444_4444);
        check("post_rst_cnt", wb_cnt, 32'd1);

        // Counter wrap.
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        #1;
        check("wrap_forced", wb_cnt, 32'hFFFF_FFFF);
        m_cnt = 32'hFFFF_FFFF;
        write_gpr(9, 32'h9999);
        #1;
        check("wrap_cnt", wb_cnt, 32'h0000_0000);
        re1 = 1; raddr1 = 9;
        #1;
        check_outputs("wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
